// File: rtl/sonic_st_adapter_pkg.sv
// Shared limits and helpers for the streaming timing adapter.
// Latency: n/a (constants and an elaboration-time function only).
// Backpressure: n/a.
package sonic_st_adapter_pkg;

  // Legal parameter ranges, checked at elaboration by the adapter top.
  localparam int MIN_DATA_WIDTH       = 1;
  localparam int MAX_DATA_WIDTH       = 256;
  localparam int MAX_IN_READY_LATENCY = 3;

  // Ceiling log2; clog2(1) = 0.
  function automatic int clog2(input int value);
    int v;
    int r;
    v = value - 1;
    r = 0;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/sonic_st_fifo_ram.sv
// Adapter storage: DEPTH x DATA_WIDTH register array, one write port, one async read port.
// Latency: write lands on the rising edge; read is combinational from rd_addr.
// Backpressure: none; the caller guarantees it never writes an unread entry.
//
// Ports: clk, wr_en/wr_addr/wr_data (write port), rd_addr/rd_data (read port).
// Contents are deliberately not reset.
module sonic_st_fifo_ram #(
  parameter int DATA_WIDTH = 2,
  parameter int DEPTH      = 4,
  parameter int AW         = 2
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [AW-1:0]         wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [AW-1:0]         rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/sonic_eth_10g_st_timing_adapter.sv
// Streaming timing adapter: absorbs upstream ready latency in a small FWFT buffer.
// Latency: 1 cycle from accepted beat to out_valid/out_data (no bypass).
// Backpressure: in_ready from occupancy only; beats arriving outside the permitted window are dropped and counted.
//
// Ports: clk, reset_n (async, active low); in_data/in_valid/in_ready upstream;
// out_data/out_valid/out_ready downstream (ready latency 0); overflow pulses on
// each dropped beat; drop_count is a saturating count of dropped beats.
module sonic_eth_10g_st_timing_adapter
  import sonic_st_adapter_pkg::*;
#(
  parameter int DATA_WIDTH       = 2,
  parameter int DEPTH            = 4,
  parameter int IN_READY_LATENCY = 0,
  parameter int IN_HAS_READY     = 1,
  parameter int CNT_WIDTH        = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  overflow,
  output logic [CNT_WIDTH-1:0]  drop_count
);

  // Address width is at least 1 so DEPTH=1 still has a legal pointer.
  localparam int AW = (clog2(DEPTH) < 1) ? 1 : clog2(DEPTH);
  // Occupancy must represent 0..DEPTH inclusive.
  localparam int OW = clog2(DEPTH) + 1;

  localparam logic [OW-1:0] DEPTH_O  = OW'(DEPTH);
  // occupancy + L + 1 <= DEPTH  <=>  occupancy <= DEPTH - L - 1
  localparam logic [OW-1:0] RDY_MAX  = OW'(DEPTH - IN_READY_LATENCY - 1);
  localparam logic [AW-1:0] PTR_LAST = AW'(DEPTH - 1);

  if (DATA_WIDTH < MIN_DATA_WIDTH || DATA_WIDTH > MAX_DATA_WIDTH) begin : g_bad_width
    $error("DATA_WIDTH out of range");
  end
  if (IN_READY_LATENCY < 0 || IN_READY_LATENCY > MAX_IN_READY_LATENCY ||
      DEPTH < IN_READY_LATENCY + 1 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("DEPTH / IN_READY_LATENCY combination not supported");
  end

  logic [AW-1:0]        wr_ptr;
  logic [AW-1:0]        rd_ptr;
  logic [OW-1:0]        occ;
  logic [CNT_WIDTH-1:0] cnt;
  logic                 full;
  logic                 pop;
  logic                 push;
  logic                 permitted;
  logic                 drop;

  assign out_valid = (occ != '0);
  assign full      = (occ == DEPTH_O);
  assign pop       = out_valid && out_ready;

  if (IN_HAS_READY != 0) begin : g_ready
    logic rdy;

    // Registered occupancy only; reset_n forces it low while in reset.
    assign rdy      = reset_n && (occ <= RDY_MAX);
    assign in_ready = rdy;

    if (IN_READY_LATENCY == 0) begin : g_lat0
      assign permitted = rdy;
    end else begin : g_hist
      localparam int HW = IN_READY_LATENCY;
      logic [HW-1:0] hist;

      // hist[k] holds in_ready from k+1 cycles ago; the oldest entry gates this cycle.
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          hist <= '0;
        end else begin
          hist <= HW'({hist, rdy});
        end
      end

      assign permitted = hist[HW-1];
    end
  end else begin : g_no_ready
    assign in_ready  = 1'b1;
    assign permitted = 1'b1;
  end

  // With ready, a permitted beat can never meet a full buffer (the ready
  // threshold reserves room for L in-flight beats); the full guard is what
  // protects the no-ready configuration, where a same-cycle pop frees a slot.
  assign push     = in_valid && permitted && (!full || pop);
  assign drop     = reset_n && in_valid && !push;
  assign overflow = drop;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
      cnt    <= '0;
    end else begin
      if (push) begin
        wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + 1'b1;
      end
      occ <= occ + OW'(push) - OW'(pop);
      if (drop && (cnt != '1)) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign drop_count = cnt;

  sonic_st_fifo_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .AW         (AW)
  ) u_ram (
    .clk     (clk),
    .wr_en   (push),
    .wr_addr (wr_ptr),
    .wr_data (in_data),
    .rd_addr (rd_ptr),
    .rd_data (out_data)
  );

endmodule

// File: tb/tb_sonic_eth_10g_st_timing_adapter.sv
// Bench for the streaming timing adapter: three instances (L=0, L=2, no-ready)
// against a queue-based reference model, plus literal directed expectations.
`timescale 1ns/1ps
module tb_sonic_eth_10g_st_timing_adapter;

  localparam int DW  = 8;
  localparam int DEP = 4;
  localparam int NI  = 3;
  localparam int LAT  [NI] = '{0, 2, 0};
  localparam int HASR [NI] = '{1, 1, 0};
  localparam int CMAX [NI] = '{65535, 65535, 7};

  logic          clk = 1'b0;
  logic          reset_n;
  logic [DW-1:0] in_data   [NI];
  logic          in_valid  [NI];
  logic          out_ready [NI];
  logic [DW-1:0] out_data  [NI];
  logic          out_valid [NI];
  logic          in_ready  [NI];
  logic          overflow  [NI];
  logic [15:0]   dc0;
  logic [15:0]   dc1;
  logic [2:0]    dc2;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  sonic_eth_10g_st_timing_adapter #(
    .DATA_WIDTH(DW), .DEPTH(DEP), .IN_READY_LATENCY(0), .IN_HAS_READY(1), .CNT_WIDTH(16)
  ) u_l0 (
    .clk(clk), .reset_n(reset_n), .in_data(in_data[0]), .in_valid(in_valid[0]),
    .in_ready(in_ready[0]), .out_data(out_data[0]), .out_valid(out_valid[0]),
    .out_ready(out_ready[0]), .overflow(overflow[0]), .drop_count(dc0)
  );

  sonic_eth_10g_st_timing_adapter #(
    .DATA_WIDTH(DW), .DEPTH(DEP), .IN_READY_LATENCY(2), .IN_HAS_READY(1), .CNT_WIDTH(16)
  ) u_l2 (
    .clk(clk), .reset_n(reset_n), .in_data(in_data[1]), .in_valid(in_valid[1]),
    .in_ready(in_ready[1]), .out_data(out_data[1]), .out_valid(out_valid[1]),
    .out_ready(out_ready[1]), .overflow(overflow[1]), .drop_count(dc1)
  );

  sonic_eth_10g_st_timing_adapter #(
    .DATA_WIDTH(DW), .DEPTH(DEP), .IN_READY_LATENCY(0), .IN_HAS_READY(0), .CNT_WIDTH(3)
  ) u_nr (
    .clk(clk), .reset_n(reset_n), .in_data(in_data[2]), .in_valid(in_valid[2]),
    .in_ready(in_ready[2]), .out_data(out_data[2]), .out_valid(out_valid[2]),
    .out_ready(out_ready[2]), .overflow(overflow[2]), .drop_count(dc2)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] dc(input int i);
    case (i)
      0:       return {16'd0, dc0};
      1:       return {16'd0, dc1};
      default: return {29'd0, dc2};
    endcase
  endfunction

  // ---------------- reference model ----------------
  // Per instance: the buffered beats in order, the in_ready values of past
  // cycles (index 0 = previous cycle), and the expected drop count.
  logic [DW-1:0] mq [NI][$];
  int            rh [NI][$];
  int            mcnt [NI];
  int            rst_events = 0;
  int            rst_seen   = 0;

  always @(negedge reset_n) rst_events++;

  task automatic model_clear();
    for (int i = 0; i < NI; i++) begin
      mq[i].delete();
      rh[i].delete();
      repeat (4) rh[i].push_back(0);
      mcnt[i] = 0;
    end
  endtask

  always @(negedge clk) begin
    if (rst_seen != rst_events || !reset_n) begin
      rst_seen = rst_events;
      model_clear();
    end
    for (int i = 0; i < NI; i++) begin
      int   occ;
      logic e_rdy;
      logic perm;
      logic pop;
      logic acc;
      occ = mq[i].size();
      if (!reset_n) begin
        chk($sformatf("rst_out_valid%0d", i), out_valid[i], 0);
        chk($sformatf("rst_in_ready%0d", i), in_ready[i], (HASR[i] != 0) ? 0 : 1);
        chk($sformatf("rst_overflow%0d", i), overflow[i], 0);
        chk($sformatf("rst_drop_count%0d", i), dc(i), 0);
      end else begin
        e_rdy = (HASR[i] == 0) || (occ + LAT[i] + 1 <= DEP);
        if (HASR[i] == 0)     perm = 1'b1;
        else if (LAT[i] == 0) perm = e_rdy;
        else                  perm = (rh[i][LAT[i]-1] != 0);
        pop = (occ > 0) && out_ready[i];
        acc = in_valid[i] && perm && ((HASR[i] != 0) || occ < DEP || pop);

        chk($sformatf("m_out_valid%0d", i), out_valid[i], (occ > 0) ? 1 : 0);
        if (occ > 0) chk($sformatf("m_out_data%0d", i), out_data[i], mq[i][0]);
        chk($sformatf("m_in_ready%0d", i), in_ready[i], e_rdy);
        chk($sformatf("m_overflow%0d", i), overflow[i], (in_valid[i] && !acc) ? 1 : 0);
        chk($sformatf("m_drop_count%0d", i), dc(i), mcnt[i]);

        rh[i].push_front(e_rdy ? 1 : 0);
        void'(rh[i].pop_back());
        if (pop) void'(mq[i].pop_front());
        if (acc) mq[i].push_back(in_data[i]);
        else if (in_valid[i] && mcnt[i] < CMAX[i]) mcnt[i]++;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int h1, h2, cur, sent;
    logic [DW-1:0] exp41 [4];
    int vp [3];
    int rp [3];

    reset_n = 1'b0;
    for (int i = 0; i < NI; i++) begin
      in_valid[i]  = 1'b0;
      in_data[i]   = '0;
      out_ready[i] = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    #1;
    chk("post_rst_in_ready", in_ready[0], 1);
    chk("post_rst_out_valid", out_valid[0], 0);
    chk("post_rst_drop_count", dc(0), 0);
    tick();

    // Back-to-back stream through an always-ready sink.
    out_ready[0] = 1'b1;
    for (int k = 0; k < 4; k++) begin
      in_valid[0] = 1'b1;
      in_data[0]  = 8'(k);
      tick();
      chk("s37_out_data", out_data[0], k);
      chk("s37_out_valid", out_valid[0], 1);
      chk("s37_in_ready", in_ready[0], 1);
    end
    in_valid[0] = 1'b0;
    tick();
    chk("s37_drained", out_valid[0], 0);
    chk("s37_drop_count", dc(0), 0);

    // Protocol violation at L=0: send while in_ready is low.
    out_ready[0] = 1'b0;
    for (int k = 0; k < 4; k++) begin
      in_valid[0] = 1'b1;
      in_data[0]  = 8'(10 + k);
      tick();
    end
    in_data[0] = 8'd99;
    #1;
    chk("s39_in_ready_low", in_ready[0], 0);
    chk("s39_overflow", overflow[0], 1);
    chk("s39_cnt_before", dc(0), 0);
    tick();
    in_valid[0] = 1'b0;
    #1;
    chk("s39_overflow_clear", overflow[0], 0);
    chk("s39_cnt_after", dc(0), 1);
    out_ready[0] = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk("s39_order", out_data[0], 10 + k);
      tick();
    end
    chk("s39_empty", out_valid[0], 0);
    out_ready[0] = 1'b0;

    // L=2 upstream sends only when in_ready was high two cycles earlier.
    out_ready[1] = 1'b0;
    h1 = 1; h2 = 1; sent = 0;
    for (int c = 0; c < 8; c++) begin
      cur = int'(in_ready[1]);
      if (c == 1) chk("s38_ready_occ1", cur, 1);
      if (c == 2) chk("s38_ready_occ2", cur, 0);
      in_valid[1] = (h2 != 0);
      if (h2 != 0) begin
        in_data[1] = 8'(20 + sent);
        sent++;
      end
      #1;
      chk("s38_overflow", overflow[1], 0);
      h2 = h1;
      h1 = cur;
      tick();
    end
    in_valid[1] = 1'b0;
    chk("s38_sent", sent, 4);
    chk("s38_drop_count", dc(1), 0);
    chk("s38_in_ready", in_ready[1], 0);
    out_ready[1] = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk("s38_order", out_data[1], 20 + k);
      tick();
    end
    chk("s38_empty", out_valid[1], 0);
    out_ready[1] = 1'b0;

    // No-ready upstream: six beats into a stalled four-entry buffer.
    out_ready[2] = 1'b0;
    for (int k = 0; k < 6; k++) begin
      in_valid[2] = 1'b1;
      in_data[2]  = 8'(30 + k);
      #1;
      chk("s40_overflow", overflow[2], (k >= 4) ? 1 : 0);
      chk("s40_in_ready", in_ready[2], 1);
      tick();
    end
    in_valid[2] = 1'b0;
    chk("s40_drop_count", dc(2), 2);

    // Full buffer, push and pop together: no drop, still full afterwards.
    out_ready[2] = 1'b1;
    in_valid[2]  = 1'b1;
    in_data[2]   = 8'd36;
    #1;
    chk("s41_overflow", overflow[2], 0);
    tick();
    chk("s41_drop_count", dc(2), 2);
    chk("s41_head", out_data[2], 31);
    out_ready[2] = 1'b0;
    in_data[2]   = 8'd37;
    #1;
    chk("s41_still_full", overflow[2], 1);
    repeat (6) tick();
    in_valid[2] = 1'b0;
    #1;
    chk("s41_cnt_saturated", dc(2), 7);
    chk("s41_overflow_clear", overflow[2], 0);
    exp41 = '{8'd31, 8'd32, 8'd33, 8'd36};
    out_ready[2] = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk("s41_order", out_data[2], exp41[k]);
      tick();
    end
    chk("s41_empty", out_valid[2], 0);
    out_ready[2] = 1'b0;

    // Mid-cycle reset pulse with three beats buffered.
    for (int k = 0; k < 3; k++) begin
      in_valid[0] = 1'b1;
      in_data[0]  = 8'(50 + k);
      tick();
    end
    in_valid[0] = 1'b0;
    chk("s42_buffered", out_valid[0], 1);
    #1 reset_n = 1'b0;
    #1;
    chk("s42_out_valid_async", out_valid[0], 0);
    chk("s42_in_ready_in_reset", in_ready[0], 0);
    chk("s42_cnt_in_reset", dc(0), 0);
    #1 reset_n = 1'b1;
    tick();
    chk("s42_in_ready_after", in_ready[0], 1);
    chk("s42_empty_after", out_valid[0], 0);
    chk("s42_nr_cnt_cleared", dc(2), 0);

    // Randomised traffic in three load regimes, checked by the model.
    vp = '{80, 50, 30};
    rp = '{30, 50, 90};
    for (int seg = 0; seg < 3; seg++) begin
      for (int c = 0; c < 1000; c++) begin
        for (int i = 0; i < NI; i++) begin
          in_valid[i]  = ($urandom_range(0, 99) < vp[seg]);
          in_data[i]   = 8'($urandom);
          out_ready[i] = ($urandom_range(0, 99) < rp[seg]);
        end
        tick();
      end
    end
    for (int i = 0; i < NI; i++) begin
      in_valid[i]  = 1'b0;
      out_ready[i] = 1'b1;
    end
    repeat (8) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
